// File: rtl/brseq_pkg.sv
// Shared opcodes, state encodings (value == debug step) and the strobe bundle
// for the branch/ldi control sequencer.
package brseq_pkg;

    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_BR   = 5'b10010;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_BR_T3  = 4'd4,
        ST_BR_T4  = 4'd5,
        ST_BR_T5  = 4'd6,
        ST_BR_T6  = 4'd7,
        ST_LDI_T3 = 4'd8,
        ST_LDI_T4 = 4'd9,
        ST_LDI_T5 = 4'd10,
        ST_HALT   = 4'd14,
        ST_TRAP   = 4'd15
    } state_e;

    typedef struct packed {
        logic pc_out;
        logic mar_in;
        logic inc_pc;
        logic zlow_in;
        logic zlow_out;
        logic pc_in;
        logic mdmux_read;
        logic ram_read;
        logic mdr_in;
        logic mdr_out;
        logic ir_in;
        logic gra;
        logic grb;
        logic rout;
        logic rin;
        logic ba_out;
        logic con_in;
        logic yin;
        logic cse_out;
        logic alu_add;
    } ctrl_t;

endpackage

// File: rtl/brseq_decode.sv
// Combinational state -> strobe decode; zero latency, no flow control.
module brseq_decode
    import brseq_pkg::*;
(
    input  state_e state,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_T0: begin
                ctrl.pc_out  = 1'b1;
                ctrl.mar_in  = 1'b1;
                ctrl.inc_pc  = 1'b1;
                ctrl.zlow_in = 1'b1;
            end
            ST_T1: begin
                // pc_in here is qualified with the last wait cycle in the top
                ctrl.zlow_out   = 1'b1;
                ctrl.pc_in      = 1'b1;
                ctrl.mdmux_read = 1'b1;
                ctrl.ram_read   = 1'b1;
                ctrl.mdr_in     = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            ST_BR_T3: begin
                ctrl.gra    = 1'b1;
                ctrl.rout   = 1'b1;
                ctrl.con_in = 1'b1;
            end
            ST_BR_T4: begin
                ctrl.pc_out = 1'b1;
                ctrl.yin    = 1'b1;
            end
            ST_BR_T5, ST_LDI_T4: begin
                ctrl.cse_out = 1'b1;
                ctrl.alu_add = 1'b1;
                ctrl.zlow_in = 1'b1;
            end
            ST_BR_T6: begin
                ctrl.zlow_out = 1'b1;
            end
            ST_LDI_T3: begin
                ctrl.grb    = 1'b1;
                ctrl.ba_out = 1'b1;
                ctrl.yin    = 1'b1;
            end
            ST_LDI_T5: begin
                ctrl.zlow_out = 1'b1;
                ctrl.gra      = 1'b1;
                ctrl.rin      = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Hardwired fetch/br/ldi/nop/halt sequencer; Moore strobes, T1 stretched by RAM_LAT.
// BRSEQ_PERF_EN adds instruction and taken-branch counters.
module branch_seq_ctrl
    import brseq_pkg::*;
#(
    parameter int OPC_W   = 5,
    parameter int RAM_LAT = 0,
    parameter int STEP_W  = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              run,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              con_ffq,
    output logic              pc_out,
    output logic              mar_in,
    output logic              inc_pc,
    output logic              zlow_in,
    output logic              zlow_out,
    output logic              pc_in,
    output logic              mdmux_read,
    output logic              ram_read,
    output logic              mdr_in,
    output logic              mdr_out,
    output logic              ir_in,
    output logic              gra,
    output logic              grb,
    output logic              rout,
    output logic              rin,
    output logic              ba_out,
    output logic              con_in,
    output logic              yin,
    output logic              cse_out,
    output logic              alu_add,
    output logic [STEP_W-1:0] step,
    output logic              halted,
    output logic              illegal
`ifdef BRSEQ_PERF_EN
    ,
    output logic [31:0]       instr_cnt,
    output logic [31:0]       br_taken_cnt
`endif
);

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       t1_last;
    ctrl_t      ctrl;

    assign t1_last = (wait_q == 4'(RAM_LAT));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE:   if (run) state_d = ST_T0;
            ST_T0: begin
                state_d = ST_T1;
                wait_d  = '0;
            end
            ST_T1: begin
                if (t1_last) begin
                    state_d = ST_T2;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            ST_T2: begin
                if (opcode == OPC_W'(OPC_BR))        state_d = ST_BR_T3;
                else if (opcode == OPC_W'(OPC_LDI))  state_d = ST_LDI_T3;
                else if (opcode == OPC_W'(OPC_NOP))  state_d = run ? ST_T0 : ST_IDLE;
                else if (opcode == OPC_W'(OPC_HALT)) state_d = ST_HALT;
                else                                 state_d = ST_TRAP;
            end
            ST_BR_T3:  state_d = ST_BR_T4;
            ST_BR_T4:  state_d = ST_BR_T5;
            ST_BR_T5:  state_d = ST_BR_T6;
            ST_LDI_T3: state_d = ST_LDI_T4;
            ST_LDI_T4: state_d = ST_LDI_T5;
            // run only matters at instruction boundaries
            ST_BR_T6, ST_LDI_T5: state_d = run ? ST_T0 : ST_IDLE;
            ST_HALT:   state_d = ST_HALT;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    brseq_decode u_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    assign pc_out     = ctrl.pc_out;
    assign mar_in     = ctrl.mar_in;
    assign inc_pc     = ctrl.inc_pc;
    assign zlow_in    = ctrl.zlow_in;
    assign zlow_out   = ctrl.zlow_out;
    assign pc_in      = (ctrl.pc_in & t1_last) | ((state_q == ST_BR_T6) & con_ffq);
    assign mdmux_read = ctrl.mdmux_read;
    assign ram_read   = ctrl.ram_read;
    assign mdr_in     = ctrl.mdr_in;
    assign mdr_out    = ctrl.mdr_out;
    assign ir_in      = ctrl.ir_in;
    assign gra        = ctrl.gra;
    assign grb        = ctrl.grb;
    assign rout       = ctrl.rout;
    assign rin        = ctrl.rin;
    assign ba_out     = ctrl.ba_out;
    assign con_in     = ctrl.con_in;
    assign yin        = ctrl.yin;
    assign cse_out    = ctrl.cse_out;
    assign alu_add    = ctrl.alu_add;

    assign step    = STEP_W'(state_q);
    assign halted  = (state_q == ST_HALT);
    assign illegal = (state_q == ST_TRAP);

`ifdef BRSEQ_PERF_EN
    logic [31:0] instr_q, instr_d, br_taken_q, br_taken_d;

    always_comb begin
        instr_d    = instr_q;
        br_taken_d = br_taken_q;
        if (state_q == ST_T2)             instr_d    = instr_q + 32'd1;
        if (state_q == ST_BR_T6 && con_ffq) br_taken_d = br_taken_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            instr_q    <= '0;
            br_taken_q <= '0;
        end else begin
            instr_q    <= instr_d;
            br_taken_q <= br_taken_d;
        end
    end

    assign instr_cnt    = instr_q;
    assign br_taken_cnt = br_taken_q;
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed bench for branch_seq_ctrl: one instance with RAM_LAT=0, one with RAM_LAT=2,
// sharing inputs; each phase checks only the instance it targets.
module tb_branch_seq_ctrl;

    // strobe bit positions in the observed 20-bit vectors
    localparam logic [19:0] M_PC_OUT   = 20'h80000;
    localparam logic [19:0] M_MAR_IN   = 20'h40000;
    localparam logic [19:0] M_INC_PC   = 20'h20000;
    localparam logic [19:0] M_ZLOW_IN  = 20'h10000;
    localparam logic [19:0] M_ZLOW_OUT = 20'h08000;
    localparam logic [19:0] M_PC_IN    = 20'h04000;
    localparam logic [19:0] M_MDMUX    = 20'h02000;
    localparam logic [19:0] M_RAM_RD   = 20'h01000;
    localparam logic [19:0] M_MDR_IN   = 20'h00800;
    localparam logic [19:0] M_MDR_OUT  = 20'h00400;
    localparam logic [19:0] M_IR_IN    = 20'h00200;
    localparam logic [19:0] M_GRA      = 20'h00100;
    localparam logic [19:0] M_GRB      = 20'h00080;
    localparam logic [19:0] M_ROUT     = 20'h00040;
    localparam logic [19:0] M_RIN      = 20'h00020;
    localparam logic [19:0] M_BA_OUT   = 20'h00010;
    localparam logic [19:0] M_CON_IN   = 20'h00008;
    localparam logic [19:0] M_YIN      = 20'h00004;
    localparam logic [19:0] M_CSE_OUT  = 20'h00002;
    localparam logic [19:0] M_ALU_ADD  = 20'h00001;

    localparam logic [19:0] E_NONE = 20'h0;
    localparam logic [19:0] E_T0   = M_PC_OUT | M_MAR_IN | M_INC_PC | M_ZLOW_IN;
    localparam logic [19:0] E_T1W  = M_ZLOW_OUT | M_MDMUX | M_RAM_RD | M_MDR_IN;
    localparam logic [19:0] E_T1   = E_T1W | M_PC_IN;
    localparam logic [19:0] E_T2   = M_MDR_OUT | M_IR_IN;
    localparam logic [19:0] E_B3   = M_GRA | M_ROUT | M_CON_IN;
    localparam logic [19:0] E_B4   = M_PC_OUT | M_YIN;
    localparam logic [19:0] E_B5   = M_CSE_OUT | M_ALU_ADD | M_ZLOW_IN;
    localparam logic [19:0] E_B6T  = M_ZLOW_OUT | M_PC_IN;
    localparam logic [19:0] E_B6N  = M_ZLOW_OUT;
    localparam logic [19:0] E_L3   = M_GRB | M_BA_OUT | M_YIN;
    localparam logic [19:0] E_L4   = M_CSE_OUT | M_ALU_ADD | M_ZLOW_IN;
    localparam logic [19:0] E_L5   = M_ZLOW_OUT | M_GRA | M_RIN;

    logic       clock = 1'b0;
    logic       clear, run, con_ffq;
    logic [4:0] opcode;
    wire [19:0] s0, s2;
    wire [3:0]  st0, st2;
    wire        h0, h2, i0, i2;
    wire [31:0] ic0, bt0, ic2, bt2;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    branch_seq_ctrl #(.OPC_W(5), .RAM_LAT(0), .STEP_W(4)) u0 (
        .clock(clock), .clear(clear), .run(run), .opcode(opcode), .con_ffq(con_ffq),
        .pc_out(s0[19]), .mar_in(s0[18]), .inc_pc(s0[17]), .zlow_in(s0[16]),
        .zlow_out(s0[15]), .pc_in(s0[14]), .mdmux_read(s0[13]), .ram_read(s0[12]),
        .mdr_in(s0[11]), .mdr_out(s0[10]), .ir_in(s0[9]), .gra(s0[8]), .grb(s0[7]),
        .rout(s0[6]), .rin(s0[5]), .ba_out(s0[4]), .con_in(s0[3]), .yin(s0[2]),
        .cse_out(s0[1]), .alu_add(s0[0]),
        .step(st0), .halted(h0), .illegal(i0)
`ifdef BRSEQ_PERF_EN
        , .instr_cnt(ic0), .br_taken_cnt(bt0)
`endif
    );

    branch_seq_ctrl #(.OPC_W(5), .RAM_LAT(2), .STEP_W(4)) u2 (
        .clock(clock), .clear(clear), .run(run), .opcode(opcode), .con_ffq(con_ffq),
        .pc_out(s2[19]), .mar_in(s2[18]), .inc_pc(s2[17]), .zlow_in(s2[16]),
        .zlow_out(s2[15]), .pc_in(s2[14]), .mdmux_read(s2[13]), .ram_read(s2[12]),
        .mdr_in(s2[11]), .mdr_out(s2[10]), .ir_in(s2[9]), .gra(s2[8]), .grb(s2[7]),
        .rout(s2[6]), .rin(s2[5]), .ba_out(s2[4]), .con_in(s2[3]), .yin(s2[2]),
        .cse_out(s2[1]), .alu_add(s2[0]),
        .step(st2), .halted(h2), .illegal(i2)
`ifdef BRSEQ_PERF_EN
        , .instr_cnt(ic2), .br_taken_cnt(bt2)
`endif
    );

`ifndef BRSEQ_PERF_EN
    assign ic0 = '0;
    assign bt0 = '0;
    assign ic2 = '0;
    assign bt2 = '0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    // advance one cycle, then check step and strobes of the selected instance
    task automatic cyc(input string tag, input bit sel2, input logic [3:0] st,
                       input logic [19:0] sb);
        tick();
        chk({tag, "_step"}, sel2 ? 32'(st2) : 32'(st0), 32'(st));
        chk({tag, "_strb"}, sel2 ? 32'(s2) : 32'(s0), 32'(sb));
    endtask

    initial begin
        clear = 1'b1; run = 1'b0; opcode = 5'b0; con_ffq = 1'b0;

        // reset / idle
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_step0", 32'(st0), 32'd0);
        chk("rst_strb0", 32'(s0), 32'd0);
        chk("rst_halt0", 32'(h0), 32'd0);
        chk("rst_ill0",  32'(i0), 32'd0);
        chk("rst_step2", 32'(st2), 32'd0);

        // branch taken, RAM_LAT=0
        clear = 1'b0; run = 1'b1; opcode = 5'b10010; con_ffq = 1'b1;
        cyc("bt_t0", 0, 4'd1, E_T0);
        cyc("bt_t1", 0, 4'd2, E_T1);
        cyc("bt_t2", 0, 4'd3, E_T2);
        cyc("bt_b3", 0, 4'd4, E_B3);
        cyc("bt_b4", 0, 4'd5, E_B4);
        cyc("bt_b5", 0, 4'd6, E_B5);
        cyc("bt_b6", 0, 4'd7, E_B6T);
        cyc("bt_nx", 0, 4'd1, E_T0);

        // branch not taken
        con_ffq = 1'b0;
        cyc("bn_t1", 0, 4'd2, E_T1);
        cyc("bn_t2", 0, 4'd3, E_T2);
        cyc("bn_b3", 0, 4'd4, E_B3);
        cyc("bn_b4", 0, 4'd5, E_B4);
        cyc("bn_b5", 0, 4'd6, E_B5);
        cyc("bn_b6", 0, 4'd7, E_B6N);
        cyc("bn_nx", 0, 4'd1, E_T0);

        // clear from mid-fetch, then ldi followed by br on RAM_LAT=2
        clear = 1'b1;
        cyc("clr_u0", 0, 4'd0, E_NONE);
        chk("clr_u2", 32'(st2), 32'd0);
        clear = 1'b0; opcode = 5'b00001;
        cyc("ld_t0",  1, 4'd1, E_T0);
        cyc("ld_t1a", 1, 4'd2, E_T1W);
        cyc("ld_t1b", 1, 4'd2, E_T1W);
        cyc("ld_t1c", 1, 4'd2, E_T1);
        cyc("ld_t2",  1, 4'd3, E_T2);
        cyc("ld_l3",  1, 4'd8, E_L3);
        cyc("ld_l4",  1, 4'd9, E_L4);
        cyc("ld_l5",  1, 4'd10, E_L5);
        opcode = 5'b10010; con_ffq = 1'b1;
        cyc("lb_t0",  1, 4'd1, E_T0);
        cyc("lb_t1a", 1, 4'd2, E_T1W);
        cyc("lb_t1b", 1, 4'd2, E_T1W);
        cyc("lb_t1c", 1, 4'd2, E_T1);
        cyc("lb_t2",  1, 4'd3, E_T2);
        cyc("lb_b3",  1, 4'd4, E_B3);
        run = 1'b0;
        cyc("lb_b4",  1, 4'd5, E_B4);
        cyc("lb_b5",  1, 4'd6, E_B5);
        cyc("lb_b6",  1, 4'd7, E_B6T);
        cyc("lb_idl", 1, 4'd0, E_NONE);
        cyc("lb_id2", 1, 4'd0, E_NONE);

        // halt
        clear = 1'b1;
        cyc("h_clr", 0, 4'd0, E_NONE);
        clear = 1'b0; run = 1'b1; opcode = 5'b11011;
        cyc("h_t0", 0, 4'd1, E_T0);
        cyc("h_t1", 0, 4'd2, E_T1);
        cyc("h_t2", 0, 4'd3, E_T2);
        for (int k = 0; k < 10; k++) begin
            cyc("h_hold", 0, 4'd14, E_NONE);
            chk("h_halted", 32'(h0), 32'd1);
        end
        clear = 1'b1;
        cyc("h_exit", 0, 4'd0, E_NONE);
        chk("h_halted_clr", 32'(h0), 32'd0);

        // illegal opcode trap, sticky across opcode changes
        clear = 1'b0; opcode = 5'b11111;
        cyc("i_t0", 0, 4'd1, E_T0);
        cyc("i_t1", 0, 4'd2, E_T1);
        cyc("i_t2", 0, 4'd3, E_T2);
        cyc("i_trap", 0, 4'd15, E_NONE);
        chk("i_ill", 32'(i0), 32'd1);
        opcode = 5'b10010;
        for (int k = 0; k < 3; k++) begin
            cyc("i_hold", 0, 4'd15, E_NONE);
            chk("i_sticky", 32'(i0), 32'd1);
        end
        clear = 1'b1;
        cyc("i_exit", 0, 4'd0, E_NONE);
        chk("i_ill_clr", 32'(i0), 32'd0);

        // clear during the T1 wait, then a full fresh wait and a nop loop-back
        clear = 1'b0; opcode = 5'b11010;
        cyc("w_t0",  1, 4'd1, E_T0);
        cyc("w_t1a", 1, 4'd2, E_T1W);
        cyc("w_t1b", 1, 4'd2, E_T1W);
        clear = 1'b1;
        cyc("w_clr", 1, 4'd0, E_NONE);
        clear = 1'b0;
        cyc("w2_t0",  1, 4'd1, E_T0);
        cyc("w2_t1a", 1, 4'd2, E_T1W);
        cyc("w2_t1b", 1, 4'd2, E_T1W);
        cyc("w2_t1c", 1, 4'd2, E_T1);
        cyc("w2_t2",  1, 4'd3, E_T2);
        cyc("w2_nop", 1, 4'd1, E_T0);

`ifdef BRSEQ_PERF_EN
        // 3 br (2 taken) + 1 ldi on RAM_LAT=0
        clear = 1'b1;
        tick();
        clear = 1'b0; run = 1'b1; opcode = 5'b10010; con_ffq = 1'b1;
        cyc("p_t0", 0, 4'd1, E_T0);
        repeat (7) tick();
        repeat (7) tick();
        con_ffq = 1'b0;
        repeat (7) tick();
        opcode = 5'b00001; run = 1'b0;
        repeat (6) tick();
        chk("p_idle", 32'(st0), 32'd0);
        chk("p_instr", ic0, 32'd4);
        chk("p_taken", bt0, 32'd2);
        clear = 1'b1;
        tick();
        chk("p_instr_clr", ic0, 32'd0);
        chk("p_taken_clr", bt0, 32'd0);
        clear = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
